// File: rtl/async_handshake_rx.sv
// Receiver for a 4-phase req/ack handshake from a foreign clock domain.
// It synchronises req into clk, captures sender data into a small FIFO and
// acknowledges. When the FIFO is full it either backpressures (holds ack low)
// or, in lossy mode, acknowledges and discards the word.
`timescale 1ns/1ps
module async_handshake_rx #(
    parameter int unsigned W           = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOSSY       = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_async,
    input  logic [W-1:0]             data_async,
    output logic                     ack,
    output logic [W-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop,
    output logic [15:0]              drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   push_c;
    logic                   pop_c;
    logic                   drop_c;
    logic                   can_accept_c;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [W-1:0]           mem [DEPTH];

    // Metastability chain for the unsynchronised request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
        end
    end

    assign req_s        = sync_q[SYNC_STAGES-1];
    assign pop_c        = out_valid && out_ready;
    assign can_accept_c = (count < CW'(DEPTH)) || pop_c;

    // Handshake state register; ack is the HOLD state bit itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign ack = (state_q == HOLD);

    // Next state plus capture/discard decisions
    always_comb begin
        state_d = state_q;
        push_c  = 1'b0;
        drop_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (can_accept_c) begin
                        push_c  = 1'b1;
                        state_d = HOLD;
                    end else if (LOSSY != 0) begin
                        drop_c  = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care after reset so no reset here
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= data_async;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_data  = mem[rd_ptr];
    assign out_valid = (count != '0);

    // Discard pulse and saturating discard counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop       <= 1'b0;
            drop_count <= '0;
        end else begin
            drop <= drop_c;
            if (drop_c && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/async_handshake_rx.md
ASYNC_HANDSHAKE_RX -- requirements
Module: async_handshake_rx

Interface
REQ-001 SHALL have parameter W, default 4, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, receive FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flops in the req synchroniser (>=2).
REQ-004 SHALL have parameter LOSSY, default 0: 0 = backpressure when full, 1 = acknowledge and drop when full.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port req_async  input  1  4-phase request from a foreign domain, unsynchronised.
REQ-008 SHALL have port data_async  input  W  sender data, stable from req rise until ack rise.
REQ-009 SHALL have port ack  output  1  4-phase acknowledge, registered.
REQ-010 SHALL have port out_data  output  W  FIFO head word.
REQ-011 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head when high with out_valid.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port drop  output  1  one-cycle pulse per word discarded (LOSSY=1 only).
REQ-015 SHALL have port drop_count  output  16  saturating count of discarded words.

Function
REQ-016 SHALL pass req_async through a SYNC_STAGES-flop chain; req_s = last flop; data_async never sampled except on the capture edge.
REQ-017 SHALL implement FSM states IDLE (ack=0), HOLD (ack=1).
REQ-018 SHALL, in IDLE with req_s=1 and (FIFO can accept or LOSSY=1), on that edge write/drop data_async, set ack=1, go HOLD.
REQ-019 SHALL, in IDLE with req_s=1, FIFO full, no pop this cycle, LOSSY=0, stay IDLE with ack=0 (stall, no loss).
REQ-020 SHALL, in HOLD with req_s=0, clear ack and return IDLE; with req_s=1 remain HOLD.
REQ-021 SHALL give latency req_async rise -> ack rise of SYNC_STAGES+1 clk edges when FIFO not full.
REQ-022 SHALL define "FIFO can accept" as count<DEPTH or pop this cycle (simultaneous push/pop when full permitted).
REQ-023 SHALL pop when out_valid && out_ready; out_data = entry at read pointer, combinational from storage.
REQ-024 SHALL drive out_valid = (count!=0); written word visible at out_data/out_valid right after the write edge.
REQ-025 SHALL update count: +1 push only, -1 pop only, unchanged on both/neither; never exceed DEPTH or underflow.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL, LOSSY=1 with FIFO full and no pop, discard word, pulse drop one cycle, increment drop_count saturating at 65535.
REQ-028 SHALL hold drop=0 and drop_count=0 permanently when LOSSY=0.
REQ-029 SHALL capture exactly one word per req/ack 4-phase cycle.

Reset
REQ-030 SHALL, on rst_n low, immediately force: ack=0, state IDLE, sync chain 0, pointers 0, count=0, out_valid=0, drop=0, drop_count=0; out_data undefined-content but unused.
REQ-031 SHALL discard all FIFO contents on reset mid-operation; a req_async still high after release is treated as a new transfer.
REQ-032 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL verify single transfer: defaults, req_async=1 data=4'h5 -> ack=1 at edge 3, out_valid=1 out_data=5; req low -> ack=0 within 3 edges.
REQ-034 SHALL verify backpressure: LOSSY=0, out_ready=0, 5 transfers 1..5 -> first 4 acked, count=4, 5th ack held 0; raise out_ready -> pops 1,2,3,4,5 in order, none lost.
REQ-035 SHALL verify lossy: LOSSY=1, out_ready=0, 6 transfers -> all acked, drop pulses twice, drop_count=2, FIFO holds 1..4.
REQ-036 SHALL verify full push+pop: count=4, out_ready=1 during capture edge -> word accepted, count stays 4, no stall.
REQ-037 SHALL verify reset mid-transfer: assert rst_n=0 while ack=1, count=2 -> ack, count, out_valid 0 immediately without clk edge.
REQ-038 SHALL verify SYNC_STAGES=3, W=8 instance: ack latency 4 edges, 8-bit data 8'hA5 intact.
